// File: rtl/n64_vmux_pkg.sv
// Shared constants for the N64 multiplexed video transmit path: widths, sync
// nibble layout, idle sync value and the four per-pixel bus phases.
package n64_vmux_pkg;

  localparam int COLOR_WIDTH_I = 7;
  localparam int SYNC_WIDTH    = 4;
  localparam int CNT_WIDTH     = 16;
  localparam int PIX_W         = SYNC_WIDTH + 3 * COLOR_WIDTH_I;

  // Sync nibble bit positions, all active low
  localparam int SYNC_VSYNC_N = 3;
  localparam int SYNC_CLAMP_N = 2;
  localparam int SYNC_HSYNC_N = 1;
  localparam int SYNC_CSYNC_N = 0;

  localparam logic [3:0] SYNC_IDLE = 4'hF;

  localparam logic [1:0] PH_SYNC = 2'd0;
  localparam logic [1:0] PH_R    = 2'd1;
  localparam logic [1:0] PH_G    = 2'd2;
  localparam logic [1:0] PH_B    = 2'd3;

  typedef struct packed {
    logic [SYNC_WIDTH-1:0]    sync;
    logic [COLOR_WIDTH_I-1:0] r;
    logic [COLOR_WIDTH_I-1:0] g;
    logic [COLOR_WIDTH_I-1:0] b;
  } pixel_t;

  function automatic pixel_t blank_pixel();
    pixel_t p;
    p.sync = SYNC_IDLE;
    p.r    = 7'h00;
    p.g    = 7'h00;
    p.b    = 7'h00;
    return p;
  endfunction

endpackage

// File: rtl/n64_pix_fifo2.sv
// Two-entry synchronous FIFO holding packed pixels between the valid/ready
// source and the fixed-rate bus serialiser. Push when full and pop when empty are ignored.
module n64_pix_fifo2
  import n64_vmux_pkg::*;
#(
  parameter int WIDTH = PIX_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [2];
  logic             wr_ptr_q;
  logic             rd_ptr_q;
  logic [1:0]       cnt_q;
  logic [1:0]       cnt_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (cnt_q == 2'd2);
  assign empty_o   = (cnt_q == 2'd0);
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;
  assign data_o    = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop_ok_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/n64_vmux.sv
// N64 video bus transmitter: buffers pixels and serialises each one as a sync
// cycle (nDSYNC low) followed by R, G and B cycles, inserting blanks on underflow.
module n64_vmux
  import n64_vmux_pkg::*;
#(
  parameter int color_width = COLOR_WIDTH_I,
  parameter int sync_width  = SYNC_WIDTH,
  parameter int cnt_width   = CNT_WIDTH
) (
  input  logic                   nCLK,
  input  logic                   RST,
  input  logic                   en_i,
  input  logic                   n15bit_mode_i,
  input  logic                   pix_valid_i,
  output logic                   pix_ready_o,
  input  logic [sync_width-1:0]  pix_sync_i,
  input  logic [color_width-1:0] pix_r_i,
  input  logic [color_width-1:0] pix_g_i,
  input  logic [color_width-1:0] pix_b_i,
  output logic                   nDSYNC_o,
  output logic [color_width-1:0] D_o,
  output logic [1:0]             phase_o,
  output logic                   underflow_o,
  output logic [cnt_width-1:0]   underflow_cnt_o
);

  localparam int PW = sync_width + 3 * color_width;
  localparam logic [PW-1:0] BLANK_PIX = {{sync_width{1'b1}}, {(3 * color_width){1'b0}}};

  logic [PW-1:0]          pix_in_s;
  logic [PW-1:0]          head_s;
  logic                   fifo_full_s;
  logic                   fifo_empty_s;
  logic                   push_s;
  logic                   pop_s;
  logic                   boundary_s;

  logic [1:0]             phase_q, phase_d;
  logic                   ndsync_q, ndsync_d;
  logic [color_width-1:0] d_q, d_d;
  logic                   uf_q, uf_d;
  logic [cnt_width-1:0]   ucnt_q, ucnt_d;
  logic [PW-1:0]          shadow_q, shadow_d;

  // 15-bit mode drops the two colour LSBs; sync cycles never pass through here
  function automatic logic [color_width-1:0] col_mask(input logic [color_width-1:0] c,
                                                       input logic full_mode);
    logic [color_width-1:0] m;
    if (full_mode) m = c;
    else           m = {c[color_width-1:2], 2'b00};
    return m;
  endfunction

  function automatic logic [color_width-1:0] sync_field(input logic [PW-1:0] pix);
    return {{(color_width - sync_width){1'b0}}, pix[PW-1 -: sync_width]};
  endfunction

  assign pix_in_s    = {pix_sync_i, pix_r_i, pix_g_i, pix_b_i};
  assign push_s      = pix_valid_i & ~fifo_full_s;
  assign boundary_s  = (phase_q == PH_B);
  assign pop_s       = boundary_s & en_i & ~fifo_empty_s;
  assign pix_ready_o = ~fifo_full_s;

  n64_pix_fifo2 #(
    .WIDTH (PW)
  ) u_fifo (
    .clk_i   (nCLK),
    .rst_i   (RST),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .data_i  (pix_in_s),
    .data_o  (head_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  always_comb begin
    phase_d  = phase_q;
    ndsync_d = 1'b1;
    d_d      = '0;
    uf_d     = 1'b0;
    ucnt_d   = ucnt_q;
    shadow_d = shadow_q;
    case (phase_q)
      PH_SYNC: begin
        phase_d = PH_R;
        d_d     = col_mask(shadow_q[3*color_width-1 -: color_width], n15bit_mode_i);
      end
      PH_R: begin
        phase_d = PH_G;
        d_d     = col_mask(shadow_q[2*color_width-1 -: color_width], n15bit_mode_i);
      end
      PH_G: begin
        phase_d = PH_B;
        d_d     = col_mask(shadow_q[color_width-1:0], n15bit_mode_i);
      end
      PH_B: begin
        // en_i only matters here, so a mid-pixel deassert still finishes R/G/B
        if (en_i) begin
          phase_d  = PH_SYNC;
          ndsync_d = 1'b0;
          if (fifo_empty_s) begin
            shadow_d = BLANK_PIX;
            uf_d     = 1'b1;
            if (ucnt_q != {cnt_width{1'b1}}) ucnt_d = ucnt_q + cnt_width'(1);
            else                             ucnt_d = ucnt_q;
          end else begin
            shadow_d = head_s;
          end
          d_d = sync_field(shadow_d);
        end else begin
          phase_d = PH_B;
        end
      end
      default: begin
        phase_d = PH_B;
      end
    endcase
  end

  always_ff @(posedge nCLK) begin
    if (RST) begin
      phase_q  <= PH_B;
      ndsync_q <= 1'b1;
      d_q      <= '0;
      uf_q     <= 1'b0;
      ucnt_q   <= '0;
      shadow_q <= '0;
    end else begin
      phase_q  <= phase_d;
      ndsync_q <= ndsync_d;
      d_q      <= d_d;
      uf_q     <= uf_d;
      ucnt_q   <= ucnt_d;
      shadow_q <= shadow_d;
    end
  end

  assign nDSYNC_o        = ndsync_q;
  assign D_o             = d_q;
  assign phase_o         = phase_q;
  assign underflow_o     = uf_q;
  assign underflow_cnt_o = ucnt_q;

endmodule

// File: tb/tb_n64_vmux.sv
// Self-checking bench for n64_vmux: directed scenarios plus random traffic,
// all compared against a queue-based pixel-stream model.
module tb_n64_vmux;
  import n64_vmux_pkg::*;

  logic nCLK = 1'b0;
  always #5 nCLK = ~nCLK;

  logic       RST = 1'b1, en = 1'b0, mode = 1'b1, valid = 1'b0;
  logic [3:0] sync = 4'h0;
  logic [6:0] pr = 7'h00, pg = 7'h00, pb = 7'h00;
  logic       ready, nd, uf;
  logic [6:0] d;
  logic [1:0] ph;
  logic [15:0] ucnt;
  logic       s_ready, s_nd, s_uf;
  logic [6:0] s_d;
  logic [1:0] s_ph;
  logic [4:0] s_cnt;

  n64_vmux dut (
    .nCLK(nCLK), .RST(RST), .en_i(en), .n15bit_mode_i(mode),
    .pix_valid_i(valid), .pix_ready_o(ready), .pix_sync_i(sync),
    .pix_r_i(pr), .pix_g_i(pg), .pix_b_i(pb),
    .nDSYNC_o(nd), .D_o(d), .phase_o(ph),
    .underflow_o(uf), .underflow_cnt_o(ucnt)
  );

  // Narrow counter instance so saturation is reachable in a short run
  n64_vmux #(.cnt_width(5)) u_sat (
    .nCLK(nCLK), .RST(RST), .en_i(1'b1), .n15bit_mode_i(1'b1),
    .pix_valid_i(1'b0), .pix_ready_o(s_ready), .pix_sync_i(4'h0),
    .pix_r_i(7'h00), .pix_g_i(7'h00), .pix_b_i(7'h00),
    .nDSYNC_o(s_nd), .D_o(s_d), .phase_o(s_ph),
    .underflow_o(s_uf), .underflow_cnt_o(s_cnt)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state: queued pixels, the pixel on the bus and its slot
  pixel_t     mq[$];
  pixel_t     cur_m;
  int         slot_m = 3;
  logic       nd_m = 1'b1, uf_m = 1'b0;
  logic [6:0] d_m = 7'h00;
  int         ucnt_m = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_edge();
    pixel_t inp;
    logic [6:0] c;
    bit acc;
    acc = valid && (mq.size() < 2);
    inp = pixel_t'({sync, pr, pg, pb});
    if (RST) begin
      mq.delete();
      slot_m = 3; nd_m = 1'b1; d_m = 7'h00; uf_m = 1'b0; ucnt_m = 0;
      cur_m = blank_pixel();
    end else begin
      uf_m = 1'b0;
      nd_m = 1'b1;
      if (slot_m == 3) begin
        if (en) begin
          if (mq.size() > 0) begin
            cur_m = mq.pop_front();
          end else begin
            cur_m = blank_pixel();
            uf_m = 1'b1;
            if (ucnt_m < 65535) ucnt_m++;
          end
          slot_m = 0;
          nd_m = 1'b0;
          d_m = {3'b000, cur_m.sync};
        end else begin
          d_m = 7'h00;
        end
      end else begin
        slot_m++;
        c = (slot_m == 1) ? cur_m.r : (slot_m == 2) ? cur_m.g : cur_m.b;
        d_m = mode ? c : (c & 7'h7C);
      end
      if (acc) mq.push_back(inp);
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge nCLK);
    model_edge();
    @(negedge nCLK);
    chk({tag, ".ready"}, {31'd0, ready}, {31'd0, mq.size() < 2});
    chk({tag, ".nd"},    {31'd0, nd},    {31'd0, nd_m});
    chk({tag, ".d"},     {25'd0, d},     {25'd0, d_m});
    chk({tag, ".ph"},    {30'd0, ph},    slot_m);
    chk({tag, ".uf"},    {31'd0, uf},    {31'd0, uf_m});
    chk({tag, ".cnt"},   {16'd0, ucnt},  ucnt_m);
  endtask

  task automatic set_pix(input logic [3:0] s, input logic [6:0] r, input logic [6:0] g,
                         input logic [6:0] b);
    sync = s; pr = r; pg = g; pb = b;
  endtask

  task automatic do_reset();
    RST = 1'b1; en = 1'b0; valid = 1'b0;
    cycle("rst");
    cycle("rst");
    chk("rst.state", {26'd0, ready, nd, d, ph, uf}, {26'd0, 1'b1, 1'b1, 7'h00, 2'd3, 1'b0});
    chk("rst.cnt", {16'd0, ucnt}, 32'd0);
    RST = 1'b0;
  endtask

  function automatic pixel_t pat(input int idx);
    pixel_t p;
    p.sync = idx[3:0];
    p.r    = idx[6:0];
    p.g    = ~idx[6:0];
    p.b    = idx[6:0] + 7'd3;
    return p;
  endfunction

  initial begin
    int emitted, last_sync, idx;
    bit acc;
    pixel_t p;

    // Single pixel after reset, then a blank
    do_reset();
    mode = 1'b1;
    valid = 1'b1; set_pix(4'h5, 7'h7F, 7'h2A, 7'h01);
    cycle("sp.push");
    valid = 1'b0; en = 1'b1;
    cycle("sp"); chk("sp.sync", {nd, d}, {1'b0, 7'h05});
    cycle("sp"); chk("sp.r", {nd, d}, {1'b1, 7'h7F});
    cycle("sp"); chk("sp.g", {nd, d}, {1'b1, 7'h2A});
    cycle("sp"); chk("sp.b", {nd, d}, {1'b1, 7'h01});
    cycle("sp"); chk("sp.blank", {nd, d, uf}, {1'b0, 7'h0F, 1'b1});

    // Three starved pixel periods
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cycle("uf");
      if (i % 4 == 0) chk("uf.sync", {nd, d, uf}, {1'b0, 7'h0F, 1'b1});
      else            chk("uf.col", {nd, d, uf}, {1'b1, 7'h00, 1'b0});
    end
    chk("uf.cnt3", {16'd0, ucnt}, 32'd3);

    // 15-bit mode masks colours only
    do_reset();
    mode = 1'b0; valid = 1'b1; set_pix(4'h3, 7'h7F, 7'h7F, 7'h7F);
    cycle("m15.push");
    valid = 1'b0; en = 1'b1;
    cycle("m15"); chk("m15.sync", {nd, d}, {1'b0, 7'h03});
    cycle("m15"); chk("m15.r", {nd, d}, {1'b1, 7'h7C});
    mode = 1'b1;

    // Enable dropped in phase 1
    do_reset();
    valid = 1'b1; set_pix(4'h5, 7'h11, 7'h22, 7'h33); cycle("en.push");
    set_pix(4'hA, 7'h44, 7'h55, 7'h66); cycle("en.push");
    valid = 1'b0; en = 1'b1;
    cycle("en"); chk("en.sync", {nd, d}, {1'b0, 7'h05});
    cycle("en"); chk("en.ph1", {30'd0, ph}, 32'd1);
    en = 1'b0;
    cycle("en"); chk("en.g", {nd, d}, {1'b1, 7'h22});
    cycle("en"); chk("en.b", {nd, d}, {1'b1, 7'h33});
    for (int i = 0; i < 3; i++) begin
      cycle("en.idle");
      chk("en.idle", {nd, d, ph, uf}, {1'b1, 7'h00, 2'd3, 1'b0});
    end
    chk("en.nocnt", {16'd0, ucnt}, 32'd0);
    en = 1'b1;
    cycle("en"); chk("en.resume", {nd, d}, {1'b0, 7'h0A});

    // Reset in phase 2 with two pixels buffered
    do_reset();
    valid = 1'b1; set_pix(4'h1, 7'h01, 7'h02, 7'h03); cycle("rm.push");
    set_pix(4'h2, 7'h04, 7'h05, 7'h06); cycle("rm.push");
    en = 1'b1; set_pix(4'h4, 7'h07, 7'h08, 7'h09);
    cycle("rm");
    cycle("rm");
    valid = 1'b0;
    cycle("rm"); chk("rm.ph2", {30'd0, ph}, 32'd2);
    RST = 1'b1;
    cycle("rm.rst");
    chk("rm.after", {25'd0, ready, nd, d, ph, ucnt[0]}, {25'd0, 1'b1, 1'b1, 7'h00, 2'd3, 1'b0});
    chk("rm.cnt", {16'd0, ucnt}, 32'd0);
    RST = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cycle("rm.post");
      if (i % 4 == 0) chk("rm.blank", {nd, d, uf}, {1'b0, 7'h0F, 1'b1});
    end

    // Back-to-back stream of 100 pixels
    do_reset();
    idx = 0; emitted = 0; last_sync = -4;
    valid = 1'b1; p = pat(0); set_pix(p.sync, p.r, p.g, p.b);
    for (int c = 0; c < 1200 && emitted < 100; c++) begin
      en = (c >= 2);
      acc = valid && ready;
      cycle("b2b");
      if (!nd) begin
        p = pat(emitted);
        chk("b2b.order", {25'd0, d}, {25'd0, 3'b000, p.sync});
        chk("b2b.uf", {31'd0, uf}, 32'd0);
        if (emitted > 0) chk("b2b.gap", c - last_sync, 32'd4);
        last_sync = c;
        emitted++;
      end
      if (acc) begin
        idx++;
        if (idx >= 100) valid = 1'b0;
        else begin p = pat(idx); set_pix(p.sync, p.r, p.g, p.b); end
      end
    end
    chk("b2b.count", emitted, 32'd100);
    chk("b2b.nouf", {16'd0, ucnt}, 32'd0);
    valid = 1'b0;

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (!(valid && !ready)) begin
        valid = ($urandom_range(0, 1) == 1);
        set_pix(4'($urandom), 7'($urandom), 7'($urandom), 7'($urandom));
      end
      en   = ($urandom_range(0, 9) != 0);
      mode = ($urandom_range(0, 1) == 1);
      cycle("rnd");
    end

    // Narrow instance has seen ~150 starved pixels since its last reset
    chk("sat.cnt", {27'd0, s_cnt}, 32'h1F);
    chk("sat.bus", {22'd0, s_ready, s_nd, s_d, s_uf},
        {22'd0, 1'b1, (s_ph != 2'd0), ((s_ph == 2'd0) ? 7'h0F : 7'h00), (s_ph == 2'd0)});

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
